// File: rtl/timer_alarm_core.sv
// Programmable 2*DATA_W countdown alarm: one-shot/periodic, sticky IRQ and overrun flags.
// Optional tick prescaler enabled by defining TIMER_ALARM_PRESCALE_EN.
module timer_alarm_core #(
    parameter int DATA_W  = 32,
    parameter int PRESC_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     ALARM_DATA,
    input  logic                  ALARM_LOAD_LO,
    input  logic                  ALARM_LOAD_HI,
    input  logic                  ALARM_START,
    input  logic                  ALARM_STOP,
    input  logic                  ALARM_PERIODIC,
    input  logic                  ALARM_ACK,
`ifdef TIMER_ALARM_PRESCALE_EN
    input  logic [PRESC_W-1:0]    ALARM_PRESC,
`endif
    output logic                  ALARM_IRQ,
    output logic                  ALARM_OVERRUN,
    output logic                  ALARM_BUSY,
    output logic [2*DATA_W-1:0]   ALARM_REMAIN
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int CNT_W = 2 * DATA_W;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   reload_q, reload_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               irq_q, irq_d;
    logic               ovr_q, ovr_d;
    logic               expire;
    logic               tick;

`ifdef TIMER_ALARM_PRESCALE_EN
    logic [PRESC_W-1:0] presc_q, presc_d;

    assign tick = (presc_q == ALARM_PRESC);

    // Prescaler only runs while counting; any control pulse or tick restarts it.
    always_comb begin
        presc_d = presc_q + 1'b1;
        if (ALARM_STOP || ALARM_START || state_q != RUN || tick) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        reload_d = reload_q;
        count_d  = count_q;
        state_d  = state_q;
        expire   = 1'b0;

        if (ALARM_LOAD_LO) reload_d[DATA_W-1:0]      = ALARM_DATA;
        if (ALARM_LOAD_HI) reload_d[CNT_W-1:DATA_W]  = ALARM_DATA;

        // Reload source is always reload_q, so same-cycle writes only affect later reloads.
        if (ALARM_STOP) begin
            state_d = IDLE;
        end else if (ALARM_START) begin
            count_d = reload_q;
            if (reload_q == '0) begin
                expire  = 1'b1;
                state_d = IDLE;
            end else begin
                state_d = RUN;
            end
        end else if (state_q == RUN && tick) begin
            if (count_q <= 1) begin
                expire = 1'b1;
                if (ALARM_PERIODIC && reload_q != '0) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = IDLE;
                end
            end else begin
                count_d = count_q - 1'b1;
            end
        end

        irq_d = irq_q;
        ovr_d = ovr_q;
        if (ALARM_ACK) begin
            irq_d = 1'b0;
            ovr_d = 1'b0;
        end
        if (expire) begin
            irq_d = 1'b1;
            if (irq_q && !ALARM_ACK) ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            reload_q <= '0;
            count_q  <= '0;
            irq_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            reload_q <= reload_d;
            count_q  <= count_d;
            irq_q    <= irq_d;
            ovr_q    <= ovr_d;
        end
    end

    assign ALARM_IRQ     = irq_q;
    assign ALARM_OVERRUN = ovr_q;
    assign ALARM_BUSY    = (state_q == RUN);
    assign ALARM_REMAIN  = count_q;

endmodule

// File: tb/tb_timer_alarm_core.sv
// Directed self-checking bench for timer_alarm_core; inputs driven and outputs sampled on negedge.
module tb_timer_alarm_core;

    localparam int DATA_W  = 32;
    localparam int PRESC_W = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [DATA_W-1:0]   data = '0;
    logic                load_lo = 1'b0, load_hi = 1'b0;
    logic                start = 1'b0, stop = 1'b0;
    logic                periodic = 1'b0, ack = 1'b0;
    logic [PRESC_W-1:0]  presc = '0;
    logic                irq, ovr, busy;
    logic [2*DATA_W-1:0] remain;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    timer_alarm_core #(.DATA_W(DATA_W), .PRESC_W(PRESC_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .ALARM_DATA     (data),
        .ALARM_LOAD_LO  (load_lo),
        .ALARM_LOAD_HI  (load_hi),
        .ALARM_START    (start),
        .ALARM_STOP     (stop),
        .ALARM_PERIODIC (periodic),
        .ALARM_ACK      (ack),
`ifdef TIMER_ALARM_PRESCALE_EN
        .ALARM_PRESC    (presc),
`endif
        .ALARM_IRQ      (irq),
        .ALARM_OVERRUN  (ovr),
        .ALARM_BUSY     (busy),
        .ALARM_REMAIN   (remain)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, obs);
        end
    endtask

    // Advance one clock edge, then drop all single-cycle pulses.
    task automatic step();
        @(negedge clk);
        load_lo = 1'b0;
        load_hi = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        ack     = 1'b0;
    endtask

    task automatic load64(input logic [63:0] v);
        data = v[31:0];
        load_lo = 1'b1;
        step();
        data = v[63:32];
        load_hi = 1'b1;
        step();
    endtask

    initial begin
        @(negedge clk);
        step();
        step();
        check("reset_irq", {63'd0, irq}, 64'd0);
        check("reset_ovr", {63'd0, ovr}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_remain", remain, 64'd0);
        rst = 1'b1;

        // One-shot, reload 5
        load64(64'd5);
        start = 1'b1;
        step();
        check("os_busy_t", {63'd0, busy}, 64'd1);
        check("os_remain_t", remain, 64'd5);
        for (int k = 4; k >= 1; k--) begin
            step();
            check("os_remain", remain, 64'(k));
            check("os_irq_early", {63'd0, irq}, 64'd0);
        end
        step();
        check("os_irq_exp", {63'd0, irq}, 64'd1);
        check("os_busy_exp", {63'd0, busy}, 64'd0);
        check("os_remain_exp", remain, 64'd0);
        ack = 1'b1;
        step();
        check("os_ack_irq", {63'd0, irq}, 64'd0);

        // Periodic, reload 3, overrun, ack coincident with expiry
        load64(64'd3);
        periodic = 1'b1;
        start = 1'b1;
        step();
        check("per_remain_t", remain, 64'd3);
        step();
        step();
        check("per_remain_t2", remain, 64'd1);
        step();
        check("per_irq_t3", {63'd0, irq}, 64'd1);
        check("per_ovr_t3", {63'd0, ovr}, 64'd0);
        check("per_remain_t3", remain, 64'd3);
        check("per_busy_t3", {63'd0, busy}, 64'd1);
        step();
        step();
        step();
        check("per_ovr_t6", {63'd0, ovr}, 64'd1);
        step();
        step();
        ack = 1'b1;
        step();
        check("per_ack_irq_t9", {63'd0, irq}, 64'd1);
        check("per_ack_ovr_t9", {63'd0, ovr}, 64'd0);
        // Reload write during RUN must not disturb the running count
        data = 32'd7;
        load_lo = 1'b1;
        step();
        check("per_wr_remain_t10", remain, 64'd2);
        step();
        data = 32'd9;
        load_lo = 1'b1;
        step();
        check("per_coinc_reload", remain, 64'd7);
        check("per_ovr_t12", {63'd0, ovr}, 64'd1);
        stop = 1'b1;
        start = 1'b1;
        step();
        check("ss_busy", {63'd0, busy}, 64'd0);
        check("ss_remain", remain, 64'd7);
        check("ss_irq", {63'd0, irq}, 64'd1);
        check("ss_ovr", {63'd0, ovr}, 64'd1);
        ack = 1'b1;
        periodic = 1'b0;
        step();
        check("ss_ack_ovr", {63'd0, ovr}, 64'd0);

        // 64-bit borrow
        data = 32'd2;
        load_lo = 1'b1;
        load_hi = 1'b1;
        step();
        check("dual_load_noeffect", remain, 64'd7);
        data = 32'd1;
        load_hi = 1'b1;
        step();
        start = 1'b1;
        step();
        check("brw_t", remain, 64'h0000_0001_0000_0002);
        step();
        step();
        check("brw_t2", remain, 64'h0000_0001_0000_0000);
        step();
        check("brw_t3", remain, 64'h0000_0000_FFFF_FFFF);
        step();
        check("brw_t4", remain, 64'h0000_0000_FFFF_FFFE);
        stop = 1'b1;
        step();
        check("brw_stop_busy", {63'd0, busy}, 64'd0);

        // START with reload 0
        data = 32'd0;
        load_lo = 1'b1;
        load_hi = 1'b1;
        step();
        check("z_irq_pre", {63'd0, irq}, 64'd0);
        start = 1'b1;
        periodic = 1'b1;
        step();
        check("z_irq", {63'd0, irq}, 64'd1);
        check("z_busy", {63'd0, busy}, 64'd0);
        check("z_remain", remain, 64'd0);
        periodic = 1'b0;

        // Reset mid-RUN
        load64(64'd4);
        start = 1'b1;
        step();
        step();
        check("rr_busy_pre", {63'd0, busy}, 64'd1);
        rst = 1'b0;
        step();
        step();
        check("rr_irq", {63'd0, irq}, 64'd0);
        check("rr_busy", {63'd0, busy}, 64'd0);
        check("rr_remain", remain, 64'd0);
        rst = 1'b1;
        start = 1'b1;
        step();
        check("rr_zero_irq", {63'd0, irq}, 64'd1);
        check("rr_zero_busy", {63'd0, busy}, 64'd0);

`ifdef TIMER_ALARM_PRESCALE_EN
        ack = 1'b1;
        step();
        load64(64'd2);
        presc = 16'd3;
        start = 1'b1;
        step();
        for (int k = 1; k < 8; k++) step();
        check("pre_irq_t7", {63'd0, irq}, 64'd0);
        step();
        check("pre_irq_t8", {63'd0, irq}, 64'd1);
        check("pre_busy_t8", {63'd0, busy}, 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
